// File: rtl/rst_seq_gen.sv
// rst_seq_gen: synchronises rst_n into sys_clk, stretches it, then releases N_DOMAINS
// active-low resets in order (domain 0 first), with software reset and last-cause reporting.
module rst_seq_gen #(
    parameter int SYNC_STAGES    = 2,
    parameter int N_DOMAINS      = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int STEP_CYCLES    = 8
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 sw_rst_req,
    output logic [N_DOMAINS-1:0] sync_rst_n,
    output logic                 rst_busy,
    output logic                 rst_done,
    output logic [1:0]           rst_cause
);
    localparam int CNT_MAX = (STRETCH_CYCLES > STEP_CYCLES) ? STRETCH_CYCLES : STEP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    localparam logic [CNT_W-1:0]     STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]     STEP_LAST    = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST     = IDX_W'(N_DOMAINS - 1);
    localparam logic [N_DOMAINS-1:0] DOM0_ONLY    = N_DOMAINS'(1);

    localparam logic [1:0] CAUSE_EXT = 2'b01;
    localparam logic [1:0] CAUSE_SW  = 2'b10;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [N_DOMAINS-1:0]   rst_d;
    logic [1:0]             cause_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs;
    logic                   sw_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rs = sync_q[SYNC_STAGES-1];

    // The first edge with the request low after a software reset anchors the
    // stretch window like the synchroniser edge does, so it is not counted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = sync_rst_n;
        cause_d = rst_cause;
        if (sw_rst_req) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rst_d   = '0;
            cause_d = CAUSE_SW;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (rs && !sw_q) begin
                        if (cnt_q == STRETCH_LAST) begin
                            cnt_d   = '0;
                            idx_d   = '0;
                            rst_d   = DOM0_ONLY;
                            state_d = (N_DOMAINS == 1) ? S_DONE : S_RELEASE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_RELEASE: begin
                    if (cnt_q == STEP_LAST) begin
                        cnt_d = '0;
                        idx_d = idx_q + 1'b1;
                        rst_d = (sync_rst_n << 1) | DOM0_ONLY;
                        if (idx_d == IDX_LAST) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    rst_d = '1;
                end
                default: begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    rst_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            sync_rst_n <= '0;
            rst_busy   <= 1'b1;
            rst_done   <= 1'b0;
            rst_cause  <= CAUSE_EXT;
            sw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sync_rst_n <= rst_d;
            rst_busy   <= (state_d != S_DONE);
            rst_done   <= (state_d == S_DONE);
            rst_cause  <= cause_d;
            sw_q       <= sw_rst_req;
        end
    end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: two configurations share one stimulus stream; a timeline model
// pushes per-edge expectations into a queue that a negedge monitor pops and compares.
module tb_rst_seq_gen;
    localparam int SYNC_A = 2, N_A = 4, STRETCH_A = 16, STEP_A = 8;
    localparam int SYNC_B = 3, N_B = 1, STRETCH_B = 1, STEP_B = 1;

    logic           sys_clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           sw_rst_req = 1'b0;
    logic [N_A-1:0] srn_a;
    logic           busy_a, done_a;
    logic [1:0]     cause_a;
    logic [N_B-1:0] srn_b;
    logic           busy_b, done_b;
    logic [1:0]     cause_b;

    rst_seq_gen #(.SYNC_STAGES(SYNC_A), .N_DOMAINS(N_A), .STRETCH_CYCLES(STRETCH_A),
                  .STEP_CYCLES(STEP_A)) dut_a (
        .sys_clk(sys_clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
        .sync_rst_n(srn_a), .rst_busy(busy_a), .rst_done(done_a), .rst_cause(cause_a));

    rst_seq_gen #(.SYNC_STAGES(SYNC_B), .N_DOMAINS(N_B), .STRETCH_CYCLES(STRETCH_B),
                  .STEP_CYCLES(STEP_B)) dut_b (
        .sys_clk(sys_clk), .rst_n(rst_n), .sw_rst_req(sw_rst_req),
        .sync_rst_n(srn_b), .rst_busy(busy_b), .rst_done(done_b), .rst_cause(cause_b));

    initial forever #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [3:0] srn_a;
        logic       busy_a, done_a;
        logic       srn_b, busy_b, done_b;
        logic [1:0] cause;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Timeline model: edge counter, edges since rst_n rose, synchroniser edge per config,
    // and the software-reset anchor (first edge with the request low).
    int         n = 0;
    int         h = 0;
    int         rs_a = -1, rs_b = -1;
    bit         sw_active = 0;
    int         sw_anchor = 0;
    logic [1:0] cause_m = 2'b01;
    int         rst_falls = 0;
    int         rst_seen = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, req);
        end
    endfunction

    function automatic void model_reset();
        h         = 0;
        rs_a      = -1;
        rs_b      = -1;
        sw_active = 0;
        sw_anchor = 0;
        cause_m   = 2'b01;
    endfunction

    function automatic int n_rel(int rs_e, int stretch, int step, int nd);
        int r = 0;
        int e;
        if (rs_e < 0 || sw_active) return 0;
        e = (rs_e > sw_anchor) ? rs_e : sw_anchor;
        for (int k = 0; k < nd; k++)
            if (n >= e + stretch + k * step) r++;
        return r;
    endfunction

    initial forever begin
        @(negedge rst_n);
        rst_falls++;
    end

    initial forever begin
        int   ra, rb;
        exp_t e;
        @(posedge sys_clk);
        n++;
        if (rst_falls != rst_seen) begin
            rst_seen = rst_falls;
            model_reset();
        end
        if (!rst_n) begin
            model_reset();
        end else begin
            h++;
            if (h == SYNC_A) rs_a = n;
            if (h == SYNC_B) rs_b = n;
            if (sw_rst_req) begin
                sw_active = 1;
                cause_m   = 2'b10;
            end else if (sw_active) begin
                sw_active = 0;
                sw_anchor = n;
            end
        end
        ra       = n_rel(rs_a, STRETCH_A, STEP_A, N_A);
        rb       = n_rel(rs_b, STRETCH_B, STEP_B, N_B);
        e.srn_a  = 4'((1 << ra) - 1);
        e.done_a = (ra == N_A);
        e.busy_a = (ra != N_A);
        e.srn_b  = (rb == N_B);
        e.done_b = (rb == N_B);
        e.busy_b = (rb != N_B);
        e.cause  = cause_m;
        exp_q.push_back(e);
    end

    initial forever begin
        exp_t e;
        @(negedge sys_clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sync_rst_n_a", 32'(srn_a), 32'(e.srn_a));
            chk("rst_busy_a", 32'(busy_a), 32'(e.busy_a));
            chk("rst_done_a", 32'(done_a), 32'(e.done_a));
            chk("rst_cause_a", 32'(cause_a), 32'(e.cause));
            chk("sync_rst_n_b", 32'(srn_b), 32'(e.srn_b));
            chk("rst_busy_b", 32'(busy_b), 32'(e.busy_b));
            chk("rst_done_b", 32'(done_b), 32'(e.done_b));
            chk("rst_cause_b", 32'(cause_b), 32'(e.cause));
        end
    end

    task automatic step(int k);
        repeat (k) @(negedge sys_clk);
        #1;
    endtask

    task automatic async_check();
        chk("async_srn_a", 32'(srn_a), 32'(0));
        chk("async_busy_a", 32'(busy_a), 32'(1));
        chk("async_done_a", 32'(done_a), 32'(0));
        chk("async_cause_a", 32'(cause_a), 32'(2'b01));
        chk("async_srn_b", 32'(srn_b), 32'(0));
        chk("async_cause_b", 32'(cause_b), 32'(2'b01));
    endtask

    task automatic rst_glitch();
        step(1);
        rst_n = 1'b0;
        #1 async_check();
        #1 rst_n = 1'b1;
    endtask

    task automatic rst_hold(int k, bit with_sw);
        step(1);
        sw_rst_req = with_sw;
        rst_n      = 1'b0;
        #1 async_check();
        step(k);
        rst_n = 1'b1;
        step(2);
        sw_rst_req = 1'b0;
    endtask

    task automatic sw_pulse(int len);
        step(1);
        sw_rst_req = 1'b1;
        step(len);
        sw_rst_req = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 async_check();
        step(3);
        rst_n = 1'b1;
        step(30);
        rst_glitch();
        step(50);
        sw_pulse(1);
        step(50);
        sw_pulse(50);
        step(28);
        sw_pulse(1);
        step(60);
        for (int it = 0; it < 16; it++) begin
            case ($urandom_range(0, 4))
                0: step($urandom_range(1, 60));
                1: begin
                    sw_pulse($urandom_range(1, 5));
                    step($urandom_range(5, 50));
                end
                2: begin
                    sw_pulse($urandom_range(20, 60));
                    step($urandom_range(10, 50));
                end
                3: begin
                    rst_glitch();
                    step($urandom_range(5, 50));
                end
                default: begin
                    rst_hold($urandom_range(1, 4), 1'($urandom_range(0, 1)));
                    step($urandom_range(5, 60));
                end
            endcase
        end
        step(50);
        chk("queue_drained", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
